// File: rtl/bcd_xs3_serial_converter.sv
// bcd_xs3_serial_converter: sequences a packed word between BCD and Excess-3, one digit per clock, LSD first
// Ports: clk, rst (async, active-high); start/mode/din request (sampled in IDLE, mode 0 = BCD->XS3, 1 = XS3->BCD);
//        busy while converting, done one-cycle completion pulse, dout result word, err illegal-digit flag of last word
module bcd_xs3_serial_converter #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [4*DIGITS-1:0] din,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] dout,
    output logic                err
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    state_t            state;
    logic [IW-1:0]     idx;
    logic [4*DIGITS-1:0] word, res, res_next;
    logic              mode_q, err_q, bad, last;
    logic [3:0]        nib, conv;
    always_comb begin
        nib = word[idx*4 +: 4];
        conv = mode_q ? nib - 4'd3 : nib + 4'd3;
        bad = mode_q ? (nib < 4'd3 || nib > 4'd12) : (nib > 4'd9);
        last = idx == IW'(DIGITS - 1);
        res_next = res;
        res_next[idx*4 +: 4] = conv;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            word   <= '0;
            res    <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dout   <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    word   <= din;
                    mode_q <= mode;
                    err_q  <= 1'b0;
                    idx    <= '0;
                    busy   <= 1'b1;
                    state  <= CONVERT;
                end
                CONVERT: begin
                    res   <= res_next;
                    err_q <= err_q | bad;
                    idx   <= idx + 1'b1;
                    if (last) begin
                        dout  <= res_next;
                        err   <= err_q | bad;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
